// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial sequence detector: state sizing and the
// elaboration-time prefix/suffix (KMP) transition functions.
package seq_det_pkg;

  localparam int MAX_N = 16;
  localparam int DEF_N = 4;
  localparam logic [DEF_N-1:0] DEF_PATTERN = 4'b1011;

  typedef logic [MAX_N-1:0] pat_t;

  // Smallest w with 2**w >= v.
  function automatic int clog2(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) w = i + 1;
    end
    return w;
  endfunction

  function automatic logic pat_bit(input pat_t pat, input int idx);
    pat_t t;
    t = pat >> idx;
    return t[0];
  endfunction

  // Length of the longest proper prefix of the N-bit pattern that is also its suffix.
  function automatic int prefix_fallback(input pat_t pat, input int n);
    int  best;
    bit  ok;
    best = 0;
    for (int l = 1; l < MAX_N; l++) begin
      if (l < n) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_N; j++) begin
          if (j < l && pat_bit(pat, n - 1 - j) != pat_bit(pat, l - 1 - j)) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Next state from S_k on bit x: longest pattern prefix that ends the string
  // (first k pattern bits ++ x). Covers both the advance and the fallback case.
  function automatic int seq_next(input pat_t pat, input int n, input int k, input logic x);
    int   best;
    int   si;
    bit   ok;
    logic sb;
    best = 0;
    for (int l = 1; l <= MAX_N; l++) begin
      if (l <= k + 1 && l <= n) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_N; j++) begin
          if (j < l) begin
            si = k + 1 - l + j;
            sb = (si < k) ? pat_bit(pat, n - 1 - si) : x;
            if (sb != pat_bit(pat, n - 1 - j)) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit saturating up-counter with increment enable; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/moore_seq_detector.sv
// Moore detector for an N-bit serial pattern (MSB first) with KMP fallback.
// Define SEQ_DET_COUNT_EN to build the saturating match counter.
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int             N       = DEF_N,
  parameter logic [N-1:0]   PATTERN = DEF_PATTERN,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int   SW  = clog2(N + 1);
  localparam pat_t PAT = pat_t'(PATTERN);
  localparam int   FB  = prefix_fallback(PAT, N);

  localparam logic [SW-1:0] S_0 = '0;
  localparam logic [SW-1:0] S_N = SW'(N);

  logic [SW-1:0] state_reg;
  logic [SW-1:0] state_next;
  logic [SW-1:0] nxt_tab [0:N][0:1];

  // Transition table is fixed at elaboration; the match row folds in the
  // overlap/non-overlap restart point before applying x.
  generate
    for (genvar gi = 0; gi <= N; gi++) begin : g_row
      for (genvar gj = 0; gj < 2; gj++) begin : g_col
        localparam int K = (gi == N) ? (OVERLAP ? FB : 0) : gi;
        assign nxt_tab[gi][gj] = SW'(seq_next(PAT, N, K, (gj != 0)));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (en) begin
      if (state_reg > S_N) begin
        state_next = S_0;
      end else begin
        state_next = nxt_tab[state_reg][x];
      end
    end
  end

  always_comb begin
    z = (state_reg == S_N);
  end

`ifdef SEQ_DET_COUNT_EN
  logic cnt_inc;
  assign cnt_inc = en && (state_next == S_N);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .cnt (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule
